// File: rtl/muldiv_issue_ctrl_pkg.sv
// Shared op codes, FSM state encoding and op-class helpers for the mul/div issue controller.
package muldiv_issue_ctrl_pkg;

    typedef logic [3:0] md_op_t;

    localparam md_op_t MD_OP_NONE  = 4'd0;
    localparam md_op_t MD_OP_DIV   = 4'd1;
    localparam md_op_t MD_OP_DIVU  = 4'd2;
    localparam md_op_t MD_OP_MFHI  = 4'd3;
    localparam md_op_t MD_OP_MFLO  = 4'd4;
    localparam md_op_t MD_OP_MTHI  = 4'd5;
    localparam md_op_t MD_OP_MTLO  = 4'd6;
    localparam md_op_t MD_OP_MUL   = 4'd7;
    localparam md_op_t MD_OP_MULT  = 4'd8;
    localparam md_op_t MD_OP_MULTU = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHORT = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } md_state_t;

    function automatic logic is_long_op(input md_op_t op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU) || (op == MD_OP_MUL) ||
               (op == MD_OP_MULT) || (op == MD_OP_MULTU);
    endfunction

    function automatic logic is_short_op(input md_op_t op);
        return (op >= MD_OP_MFHI) && (op <= MD_OP_MTLO);
    endfunction

    function automatic logic is_hilo_write(input md_op_t op);
        return (op == MD_OP_MTHI) || (op == MD_OP_MTLO);
    endfunction

endpackage

// File: rtl/muldiv_issue_ctrl_if.sv
// Issue-side request/response handshake between decode and the mul/div controller.
interface muldiv_issue_ctrl_if;
    import muldiv_issue_ctrl_pkg::*;

    logic        req_valid;
    logic        req_ready;
    md_op_t      req_op;
    logic [31:0] req_rs;
    logic [31:0] req_rt;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;

    modport master (
        output req_valid, req_op, req_rs, req_rt, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_op, req_rs, req_rt, resp_ready,
        output req_ready, resp_valid, resp_data
    );

endinterface

// File: rtl/muldiv_watchdog.sv
// Counts stalled cycles of one long op and raises a sticky timeout flag at the limit.
module muldiv_watchdog #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic Clk,
    input  logic reset,
    input  logic start,
    input  logic active,
    output logic timeout
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    // The counter saturates at the limit; the flag only clears on reset.
    always_ff @(posedge Clk) begin
        if (reset) begin
            count   <= '0;
            timeout <= 1'b0;
        end else if (start) begin
            count <= '0;
        end else if (active && (count != LIMIT)) begin
            count <= count + 1'b1;
            if (count == LIMIT - 1'b1) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// Sequencer between issue and the shared multiply/divide unit: launch, hold, complete, respond.
module muldiv_issue_ctrl
    import muldiv_issue_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic                 Clk,
    input  logic                 reset,
    muldiv_issue_ctrl_if.slave   issue,
    input  logic                 flush,
    output logic                 hilo_busy,
    output logic                 md_timeout,
    output md_op_t               md_op,
    output logic [31:0]          md_rs,
    output logic [31:0]          md_rt,
    output logic                 md_enable,
    input  logic                 md_stall,
    input  logic [31:0]          md_res
);

    md_state_t   state, state_next;
    md_op_t      md_op_next;
    logic [31:0] md_rs_next, md_rt_next;
    logic        resp_valid_q, resp_valid_next;
    logic [31:0] resp_data_q, resp_data_next;
    logic        hilo_busy_next;
    logic        accept;
    logic        wd_start;
    logic        wd_active;

    assign issue.req_ready  = (state == IDLE) && !resp_valid_q && !flush && !reset;
    assign issue.resp_valid = resp_valid_q;
    assign issue.resp_data  = resp_data_q;
    assign accept           = issue.req_valid && issue.req_ready;
    assign md_enable        = 1'b1;
    assign wd_active        = ((state == RUN) || (state == DRAIN)) && md_stall;

    always_ff @(posedge Clk) begin
        if (reset) begin
            state        <= IDLE;
            md_op        <= MD_OP_NONE;
            md_rs        <= '0;
            md_rt        <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            hilo_busy    <= 1'b0;
        end else begin
            state        <= state_next;
            md_op        <= md_op_next;
            md_rs        <= md_rs_next;
            md_rt        <= md_rt_next;
            resp_valid_q <= resp_valid_next;
            resp_data_q  <= resp_data_next;
            hilo_busy    <= hilo_busy_next;
        end
    end

    // The unit has no abort, so a flushed long op is drained and only its result dropped.
    always_comb begin
        state_next      = state;
        md_op_next      = md_op;
        md_rs_next      = md_rs;
        md_rt_next      = md_rt;
        resp_valid_next = resp_valid_q;
        resp_data_next  = resp_data_q;
        hilo_busy_next  = hilo_busy;
        wd_start        = 1'b0;

        if (resp_valid_q && (issue.resp_ready || flush)) begin
            resp_valid_next = 1'b0;
        end

        case (state)
            IDLE: begin
                if (accept && (is_long_op(issue.req_op) || is_short_op(issue.req_op))) begin
                    md_op_next = issue.req_op;
                    md_rs_next = issue.req_rs;
                    md_rt_next = issue.req_rt;
                    if (is_long_op(issue.req_op)) begin
                        hilo_busy_next = 1'b1;
                        wd_start       = 1'b1;
                        state_next     = RUN;
                    end else begin
                        hilo_busy_next = is_hilo_write(issue.req_op);
                        state_next     = SHORT;
                    end
                end
            end
            SHORT: begin
                md_op_next = MD_OP_NONE;
                state_next = IDLE;
                if (is_hilo_write(md_op)) begin
                    hilo_busy_next = 1'b0;
                end else if (!flush) begin
                    resp_valid_next = 1'b1;
                    resp_data_next  = md_res;
                end
            end
            RUN: begin
                if (!md_stall) begin
                    md_op_next     = MD_OP_NONE;
                    hilo_busy_next = 1'b0;
                    state_next     = IDLE;
                    if ((md_op == MD_OP_MUL) && !flush) begin
                        resp_valid_next = 1'b1;
                        resp_data_next  = md_res;
                    end
                end else if (flush) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!md_stall) begin
                    md_op_next     = MD_OP_NONE;
                    hilo_busy_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    muldiv_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .Clk     (Clk),
        .reset   (reset),
        .start   (wd_start),
        .active  (wd_active),
        .timeout (md_timeout)
    );

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Directed bench for muldiv_issue_ctrl with a behavioural mul/div unit and a transaction-level reference.
module tb_muldiv_issue_ctrl;
    import muldiv_issue_ctrl_pkg::*;

    localparam int TIMEOUT_CYCLES = 64;

    logic        Clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        hilo_busy;
    logic        md_timeout;
    md_op_t      md_op;
    logic [31:0] md_rs, md_rt, md_res;
    logic        md_enable;
    logic        md_stall;

    int vectors    = 0;
    int miscompares = 0;

    muldiv_issue_ctrl_if issue();

    muldiv_issue_ctrl #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(7)) dut (
        .Clk        (Clk),
        .reset      (reset),
        .issue      (issue),
        .flush      (flush),
        .hilo_busy  (hilo_busy),
        .md_timeout (md_timeout),
        .md_op      (md_op),
        .md_rs      (md_rs),
        .md_rt      (md_rt),
        .md_enable  (md_enable),
        .md_stall   (md_stall),
        .md_res     (md_res)
    );

    always #5 Clk = ~Clk;

    function automatic int op_latency(input md_op_t op);
        if ((op == MD_OP_MUL) || (op == MD_OP_MULT) || (op == MD_OP_MULTU)) return 3;
        if ((op == MD_OP_DIV) || (op == MD_OP_DIVU)) return 6;
        return 0;
    endfunction

    // Architectural result {HI, LO} of a long op.
    function automatic logic [63:0] hilo_result(input md_op_t op, input logic [31:0] rs, input logic [31:0] rt);
        logic [63:0] r;
        r = '0;
        case (op)
            MD_OP_MULT, MD_OP_MUL: r = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
            MD_OP_MULTU:           r = {32'd0, rs} * {32'd0, rt};
            MD_OP_DIV: if (rt != 0) begin
                r[31:0]  = $signed(rs) / $signed(rt);
                r[63:32] = $signed(rs) % $signed(rt);
            end
            MD_OP_DIVU: if (rt != 0) begin
                r[31:0]  = rs / rt;
                r[63:32] = rs % rt;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Behavioural mul/div unit: stalls for a fixed latency after launch, re-arms when md_op returns to 0.
    int          unit_cnt = 0;
    int          unit_lat;
    int          lat_override = 0;
    int          unit_launches = 0;
    md_op_t      prev_md_op = MD_OP_NONE;
    logic [31:0] u_hi = '0, u_lo = '0;
    logic [63:0] mul_full;

    always_comb begin
        unit_lat = (lat_override != 0) ? lat_override : op_latency(md_op);
        mul_full = hilo_result(MD_OP_MUL, md_rs, md_rt);
        md_stall = is_long_op(md_op) && (unit_cnt < unit_lat);
        case (md_op)
            MD_OP_MFHI: md_res = u_hi;
            MD_OP_MFLO: md_res = u_lo;
            MD_OP_MUL:  md_res = mul_full[31:0];
            default:    md_res = 32'd0;
        endcase
    end

    always @(posedge Clk) begin
        if (reset) begin
            unit_cnt      <= 0;
            unit_launches <= 0;
            prev_md_op    <= MD_OP_NONE;
            u_hi          <= '0;
            u_lo          <= '0;
        end else begin
            unit_cnt   <= is_long_op(md_op) ? unit_cnt + 1 : 0;
            prev_md_op <= md_op;
            if (is_long_op(md_op) && (prev_md_op == MD_OP_NONE)) unit_launches <= unit_launches + 1;
            if (is_long_op(md_op) && !md_stall && (md_op != MD_OP_MUL)) {u_hi, u_lo} <= hilo_result(md_op, md_rs, md_rt);
            if (md_op == MD_OP_MTHI) u_hi <= md_rs;
            if (md_op == MD_OP_MTLO) u_lo <= md_rs;
        end
    end

    // Reference: tracks the op in flight by age, its kill status and the pending response.
    md_op_t      m_op = MD_OP_NONE;
    int          m_age = 0, m_stalled = 0;
    logic        m_killed = 1'b0, m_resp_pending = 1'b0, m_timeout = 1'b0, m_accept, model_live = 1'b0;
    logic [31:0] m_rs = '0, m_rt = '0, m_resp_data = '0, m_hi = '0, m_lo = '0;
    logic [63:0] m_tmp;

    always @(posedge Clk) begin
        if (reset) begin
            model_live = 1'b1;
            m_op = MD_OP_NONE; m_resp_pending = 1'b0; m_resp_data = '0;
            m_timeout = 1'b0; m_hi = '0; m_lo = '0; m_killed = 1'b0;
        end else begin
            m_accept = (m_op == MD_OP_NONE) && !m_resp_pending && !flush && issue.req_valid;
            if (m_resp_pending && (issue.resp_ready || flush)) m_resp_pending = 1'b0;
            if (is_long_op(m_op)) begin
                if (m_age >= ((lat_override != 0) ? lat_override : op_latency(m_op))) begin
                    m_tmp = hilo_result(m_op, m_rs, m_rt);
                    if (m_op == MD_OP_MUL) begin
                        if (!flush && !m_killed) begin
                            m_resp_pending = 1'b1;
                            m_resp_data    = m_tmp[31:0];
                        end
                    end else begin
                        {m_hi, m_lo} = m_tmp;
                    end
                    m_op = MD_OP_NONE;
                end else begin
                    if (flush) m_killed = 1'b1;
                    m_stalled++;
                    if (m_stalled == TIMEOUT_CYCLES) m_timeout = 1'b1;
                    m_age++;
                end
            end else if (m_op != MD_OP_NONE) begin
                if (m_op == MD_OP_MTHI) m_hi = m_rs;
                if (m_op == MD_OP_MTLO) m_lo = m_rs;
                if (!flush && ((m_op == MD_OP_MFHI) || (m_op == MD_OP_MFLO))) begin
                    m_resp_pending = 1'b1;
                    m_resp_data    = (m_op == MD_OP_MFHI) ? m_hi : m_lo;
                end
                m_op = MD_OP_NONE;
            end else if (m_accept && (is_long_op(issue.req_op) || is_short_op(issue.req_op))) begin
                m_op = issue.req_op; m_rs = issue.req_rs; m_rt = issue.req_rt;
                m_age = 0; m_stalled = 0; m_killed = 1'b0;
            end
        end
    end

    always @(negedge Clk) begin
        if (model_live) begin
            checkOutput("req_ready", issue.req_ready,
                        !reset && (m_op == MD_OP_NONE) && !m_resp_pending && !flush);
            checkOutput("resp_valid", issue.resp_valid, m_resp_pending);
            checkOutput("resp_data", issue.resp_data, m_resp_data);
            checkOutput("hilo_busy", hilo_busy, is_long_op(m_op) || is_hilo_write(m_op));
            checkOutput("md_op", md_op, m_op);
            checkOutput("md_timeout", md_timeout, m_timeout);
            checkOutput("md_enable", md_enable, 1'b1);
            if (m_op != MD_OP_NONE) begin
                checkOutput("md_rs", md_rs, m_rs);
                checkOutput("md_rt", md_rt, m_rt);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic applyStimulus(input md_op_t op, input logic [31:0] rs, input logic [31:0] rt);
        logic ok;
        ok = 1'b0;
        issue.req_valid = 1'b1;
        issue.req_op    = op;
        issue.req_rs    = rs;
        issue.req_rt    = rt;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge Clk);
            if (issue.req_ready) ok = 1'b1;
        end
        if (!ok) checkOutput("accept_bound", 32'd0, 32'd1);
        tick();
        issue.req_valid = 1'b0;
    endtask

    task automatic waitResp(input string name, input logic [31:0] exp);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge Clk);
            if (issue.resp_valid) seen = 1'b1;
        end
        if (seen) checkOutput(name, issue.resp_data, exp);
        else      checkOutput({name, "_bound"}, 32'd0, 32'd1);
        tick();
    endtask

    task automatic waitHiloFree();
        logic freed;
        freed = 1'b0;
        for (int i = 0; i < 300 && !freed; i++) begin
            @(negedge Clk);
            if (!hilo_busy) freed = 1'b1;
            else checkOutput("busy_req_ready", issue.req_ready, 1'b0);
        end
        if (!freed) checkOutput("hilo_free_bound", 32'd0, 32'd1);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        issue.req_valid = 1'b0; issue.req_op = MD_OP_NONE; issue.req_rs = '0; issue.req_rt = '0;
        issue.resp_ready = 1'b1;
        tick();
        @(negedge Clk);
        checkOutput("reset_req_ready", issue.req_ready, 1'b0);
        checkOutput("reset_md_op", md_op, 4'd0);
        checkOutput("reset_md_enable", md_enable, 1'b1);
        checkOutput("reset_timeout", md_timeout, 1'b0);
        tick();
        reset = 1'b0;
        tick();

        applyStimulus(MD_OP_MULT, 32'hFFFF_FFFE, 32'd3);
        @(negedge Clk);
        checkOutput("mult_busy", hilo_busy, 1'b1);
        waitHiloFree();
        applyStimulus(MD_OP_MFLO, '0, '0);
        waitResp("mult_lo", 32'hFFFF_FFFA);
        applyStimulus(MD_OP_MFHI, '0, '0);
        waitResp("mult_hi", 32'hFFFF_FFFF);

        applyStimulus(MD_OP_DIV, 32'hFFFF_FFF9, 32'd2);
        waitHiloFree();
        applyStimulus(MD_OP_MFLO, '0, '0);
        waitResp("div_quot", 32'hFFFF_FFFD);
        applyStimulus(MD_OP_MFHI, '0, '0);
        waitResp("div_rem", 32'hFFFF_FFFF);

        issue.resp_ready = 1'b0;
        applyStimulus(MD_OP_MUL, 32'd6, 32'd7);
        for (int i = 0; i < 50 && !issue.resp_valid; i++) @(negedge Clk);
        #1;
        issue.req_valid = 1'b1; issue.req_op = MD_OP_MFHI;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            checkOutput("mul_hold_valid", issue.resp_valid, 1'b1);
            checkOutput("mul_hold_data", issue.resp_data, 32'd42);
            checkOutput("mul_hold_ready", issue.req_ready, 1'b0);
        end
        #1;
        issue.resp_ready = 1'b1;
        applyStimulus(MD_OP_MFHI, '0, '0);
        waitResp("mul_then_mfhi", 32'hFFFF_FFFF);

        applyStimulus(MD_OP_DIVU, 32'd100, 32'd7);
        tick();
        tick();
        flush = 1'b1;
        @(negedge Clk);
        checkOutput("drain_md_op", md_op, MD_OP_DIVU);
        tick();
        flush = 1'b0;
        waitHiloFree();
        checkOutput("drain_no_resp", issue.resp_valid, 1'b0);
        applyStimulus(MD_OP_MFLO, '0, '0);
        waitResp("divu_quot", 32'd14);
        applyStimulus(MD_OP_MFHI, '0, '0);
        waitResp("divu_rem", 32'd2);

        applyStimulus(MD_OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        applyStimulus(MD_OP_MULTU, 32'h0001_0000, 32'h0001_0000);
        waitHiloFree();
        applyStimulus(MD_OP_MFLO, '0, '0);
        waitResp("multu2_lo", 32'd0);
        applyStimulus(MD_OP_MFHI, '0, '0);
        waitResp("multu2_hi", 32'd1);

        issue.req_valid = 1'b1; issue.req_op = MD_OP_MFLO; flush = 1'b1;
        @(negedge Clk);
        checkOutput("flush_idle_ready", issue.req_ready, 1'b0);
        tick();
        flush = 1'b0; issue.req_valid = 1'b0;
        @(negedge Clk);
        checkOutput("flush_idle_not_taken", md_op, 4'd0);

        applyStimulus(MD_OP_MTHI, 32'hCAFE_0001, '0);
        flush = 1'b1;
        @(negedge Clk);
        checkOutput("mthi_busy", hilo_busy, 1'b1);
        tick();
        flush = 1'b0;
        applyStimulus(MD_OP_MFHI, '0, '0);
        waitResp("mthi_survives_flush", 32'hCAFE_0001);

        applyStimulus(MD_OP_MFLO, '0, '0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge Clk);
        checkOutput("short_flush_no_resp", issue.resp_valid, 1'b0);

        applyStimulus(4'd12, 32'h1234_5678, 32'd1);
        @(negedge Clk);
        checkOutput("illegal_md_op", md_op, 4'd0);
        checkOutput("illegal_busy", hilo_busy, 1'b0);
        tick();

        lat_override = 80;
        applyStimulus(MD_OP_MULT, 32'd5, 32'd5);
        repeat (63) tick();
        @(negedge Clk);
        checkOutput("timeout_before_64", md_timeout, 1'b0);
        tick();
        @(negedge Clk);
        checkOutput("timeout_at_64", md_timeout, 1'b1);
        waitHiloFree();
        checkOutput("timeout_sticky", md_timeout, 1'b1);
        checkOutput("launch_count", unit_launches, 32'd7);
        tick();
        lat_override = 0;
        reset = 1'b1;
        tick();
        @(negedge Clk);
        checkOutput("timeout_reset_clear", md_timeout, 1'b0);
        tick();
        reset = 1'b0;
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/muldiv_issue_ctrl.md
Name: muldiv_issue_ctrl

Overview:
- Sequencer between decode/issue and the shared multiply/divide unit.
- Accepts one op per valid/ready handshake and holds operands and op code stable for the unit's whole multi-cycle run.
- Detects completion from the unit's stall line, returns MUL/MFHI/MFLO results on a response handshake, and exports a HI/LO-busy interlock.
- Handles pipeline flush, which discards results; a watchdog timeout raises a sticky error flag.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles a long op may stall before md_timeout sets.
- CNT_W, 7, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- Clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  op offered by issue stage
- req_ready  out  1  controller accepts op this cycle
- req_op  in  4  op code: 1 DIV, 2 DIVU, 3 MFHI, 4 MFLO, 5 MTHI, 6 MTLO, 7 MUL, 8 MULT, 9 MULTU
- req_rs  in  32  rs operand
- req_rt  in  32  rt operand
- flush  in  1  kill current/pending op; results discarded
- resp_valid  out  1  result available (MUL, MFHI, MFLO only)
- resp_ready  in  1  consumer takes result
- resp_data  out  32  result value
- hilo_busy  out  1  HI/LO write outstanding (long op or MTHI/MTLO in flight)
- md_timeout  out  1  sticky watchdog error
- md_op  out  4  op code to unit; 0 = idle
- md_rs  out  32  operand to unit
- md_rt  out  32  operand to unit
- md_enable  out  1  unit clock enable
- md_stall  in  1  unit stall (1 = busy on long op)
- md_res  in  32  unit combinational result

Behaviour:
- Reset values: md_op=0, md_rs=md_rt=0, md_enable=1, req_ready=0 during the reset cycle, resp_valid=0, resp_data=0, hilo_busy=0, md_timeout=0, state=IDLE, counter=0.
- Long ops: 1, 2, 7, 8, 9. Short ops: 3–6. Illegal codes (0, ≥10) are accepted and treated as a no-op; no response is produced.
- States:
  - IDLE: req_ready=1 iff resp_valid=0. Handshake latches op, rs and rt into md_* regs. Long op → RUN, hilo_busy=1. Short op → SHORT.
  - SHORT: one cycle with md_op driven.
    - MFHI/MFLO: capture md_res into resp_data and set resp_valid.
    - MTHI/MTLO: the unit writes HI/LO at this edge; clear hilo_busy.
    - Next state IDLE, md_op=0.
  - RUN: md_op held. Completion = md_stall==0 sampled in RUN.
    - On completion: MUL captures md_res into resp_data and sets resp_valid; all long ops clear hilo_busy; md_op←0; go to IDLE.
    - Counter increments each RUN cycle; when it reaches TIMEOUT_CYCLES, md_timeout←1 (sticky until reset). State is unchanged.
  - DRAIN: entered on flush while in RUN. The unit has no abort, so md_op stays held until completion. The result is not captured and resp_valid stays 0. hilo_busy stays 1 until completion, since HI/LO is still overwritten.
- md_op must return to 0 for at least one cycle after a long-op completion. The unit then re-arms at status 0, so back-to-back long ops are legal with one idle cycle between them. Minimum long-op occupancy is 4 cycles (mult: 2 pipe stages, plus 1 launch cycle and 1 done cycle).
- Flush:
  - In IDLE: same-cycle request not accepted; req_ready forced 0.
  - In SHORT: MFHI/MFLO response suppressed. MTHI/MTLO still completes (architectural write already issued).
  - Clears a pending resp_valid.
  - Flush and completion in the same cycle: completion wins for HI/LO, the response is discarded, and the next state is IDLE.
- Response: resp_valid held with resp_data stable until resp_ready. No new request accepted while resp_valid=1.
- reset mid-RUN: all state cleared; the unit is reset by the same signal.
- md_enable is constant 1 (reserved for a future pipeline-freeze hook).

Decomposition:
- Shared package: MD_OP_* localparams (0–9), an is_long_op function, and state encodings IDLE/SHORT/RUN/DRAIN.
- One sub-module is natural: muldiv_watchdog (counter plus sticky flag, with clear-on-start).

Test Plan:
- MULT rs=0xFFFFFFFE, rt=3: unit stall low after 4 cycles → hilo_busy falls; then MFLO resp_data=0xFFFFFFFA and MFHI resp_data=0xFFFFFFFF.
- DIV rs=-7, rt=2 then MFLO/MFHI: resp_data=0xFFFFFFFD, then 0xFFFFFFFF. req_ready=0 throughout RUN.
- MUL rs=6, rt=7 with resp_ready=0 for 5 cycles: resp_valid held with 42 stable; next req not accepted until the handshake.
- Flush 2 cycles into DIVU 100/7: md_op held until stall low, no resp_valid, then MFLO returns 14 (HI/LO still written).
- Back-to-back MULTU, MULTU: md_op returns to 0 for ≥1 cycle between; second result correct; no double-launch.
- Bench model holds md_stall=1 for 80 cycles with TIMEOUT_CYCLES=64: md_timeout rises at cycle 64 of RUN, stays 1 after completion, and clears only on reset.
